// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: default widths, the buffered
// request record and the winner-select encoding.
package wb_pkg;

    localparam int REGISTERS_DEF = 32;
    localparam int WIDTH_DEF     = 32;
    localparam int ADDR_W_DEF    = $clog2(REGISTERS_DEF);

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] rd;
        logic [WIDTH_DEF-1:0]  data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LD
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered load results. No fall-through: an entry
// written at a posedge becomes visible at the head from the next cycle on.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_req_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  T                       wdata_i,
    input  logic                   pop_i,
    output T                       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T               mem_q [DEPTH];
    logic [PW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  cnt_q;
    logic           do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage needs no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the ALU and buffered load results onto the register file write
// port. Optional same-cycle forwarding outputs under `WB_BYPASS_EN.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter  int REGISTERS    = REGISTERS_DEF,
    parameter  int WIDTH        = WIDTH_DEF,
    parameter  int LD_DEPTH     = 4,
    parameter  int STARVE_LIMIT = 3,
    localparam int ADDR_W       = $clog2(REGISTERS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [WIDTH-1:0]  alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [WIDTH-1:0]  ld_data,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data,
    output logic              ld_pending
`ifdef WB_BYPASS_EN
    ,
    output logic              byp_valid,
    output logic [ADDR_W-1:0] byp_addr,
    output logic [WIDTH-1:0]  byp_data
`endif
);

    localparam int CW = $clog2(LD_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [WIDTH-1:0]  data;
    } req_t;

    req_t              ld_in, ld_head, win;
    wb_src_t           src;
    logic              ld_full, ld_empty, ld_push, ld_pop;
    logic [CW-1:0]     ld_count;
    logic              force_ld, alu_fire, alu_wr;
    logic [SW-1:0]     starve_q, starve_d;
    logic              wb_we_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [WIDTH-1:0]  wb_data_q;

    assign force_ld   = (starve_q == SW'(STARVE_LIMIT));
    assign alu_ready  = !force_ld;
    assign alu_fire   = alu_valid && alu_ready;
    assign alu_wr     = alu_fire && (alu_rd != '0);
    assign ld_ready   = !ld_full;
    // x0 loads complete the handshake but never occupy a slot.
    assign ld_push    = ld_valid && ld_ready && (ld_rd != '0);
    assign ld_pop     = !alu_wr && !ld_empty;
    assign ld_pending = (ld_count != '0);
    assign ld_in      = '{rd: ld_rd, data: ld_data};

    wb_fifo #(
        .DEPTH (LD_DEPTH),
        .T     (req_t)
    ) u_ld_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ld_push),
        .wdata_i (ld_in),
        .pop_i   (ld_pop),
        .rdata_o (ld_head),
        .full_o  (ld_full),
        .empty_o (ld_empty),
        .count_o (ld_count)
    );

    always_comb begin
        src      = SRC_NONE;
        win      = '0;
        starve_d = starve_q;
        if (alu_wr) begin
            src      = SRC_ALU;
            win.rd   = alu_rd;
            win.data = alu_data;
        end else if (ld_pop) begin
            src = SRC_LD;
            win = ld_head;
        end
        // Non-empty without a pop can only mean the ALU took the port.
        if (ld_empty || ld_pop)
            starve_d = '0;
        else if (!force_ld)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            starve_q <= starve_d;
            wb_we_q  <= (src != SRC_NONE);
            if (src != SRC_NONE) begin
                wb_addr_q <= win.rd;
                wb_data_q <= win.data;
            end
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;

`ifdef WB_BYPASS_EN
    assign byp_valid = (src != SRC_NONE);
    assign byp_addr  = win.rd;
    assign byp_data  = win.data;
`endif

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the core's register file.
- Merges two result producers onto the register file's single write port (we3/a3/wd3):
  - the single-cycle ALU path;
  - the variable-latency load path, which is buffered.
- Fixed ALU priority with a starvation guard for loads.
- Writes to x0 are filtered out before they reach the write port.

Parameters:
- REGISTERS, 32: number of architectural registers; ADDR_W = $clog2(REGISTERS) is a derived localparam.
- WIDTH, 32: data width.
- LD_DEPTH, 4: load result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 3: consecutive ALU wins with a non-empty load FIFO before the ALU is held off (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is high.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  load FIFO not full.
- ld_rd  in  ADDR_W  load destination register.
- ld_data  in  WIDTH  load data.
- wb_we  out  1  register file write enable (drives we3).
- wb_addr  out  ADDR_W  write address (drives a3).
- wb_data  out  WIDTH  write data (drives wd3).
- ld_pending  out  1  load FIFO non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - wb_we=0, wb_addr=0, wb_data=0.
  - FIFO empty, starve_cnt=0, ld_pending=0.
  - ld_ready=1, alu_ready=1.
  - Reset mid-operation discards all buffered loads and drops wb_we immediately.
- Load push:
  - Fire = ld_valid && ld_ready; ld_ready = (count != LD_DEPTH).
  - A fire with ld_rd==0 is accepted and discarded, not stored.
- FIFO has no fall-through. Load latency:
  - An entry pushed at the end of cycle c is poppable in c+1.
  - wb_we is high in c+2 at the earliest.
- Simultaneous push and pop is allowed whenever the FIFO is not full; count is unchanged.
- force = (starve_cnt == STARVE_LIMIT); alu_ready = !force.
- Each cycle:
  - ALU fire (alu_valid && alu_ready) with alu_rd!=0: ALU wins the port; the FIFO does not pop.
  - ALU fire with alu_rd==0: consumed without a write; the FIFO head may pop in the same cycle.
  - Otherwise, if the FIFO is non-empty: pop the head and write it.
- Output register:
  - The winner is registered into wb_we/wb_addr/wb_data at the next posedge, so ALU latency is 1 cycle.
  - With no winner, wb_we=0 and wb_addr/wb_data hold their last values.
- starve_cnt:
  - +1 when the ALU wins while the FIFO is non-empty.
  - Cleared on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT. When force is asserted the FIFO pops that cycle, so the counter clears the next cycle.
- wb_we is never asserted with wb_addr==0.
- Ordering:
  - Writes from each source retire in that source's order.
  - Inter-source ordering to the same rd is the hazard unit's responsibility; this block does not reorder or check it.
- ld_pending = (count != 0), registered-state derived.

Optional Feature:
- WB_BYPASS_EN:
  - When defined, adds outputs byp_valid (1), byp_addr (ADDR_W) and byp_data (WIDTH), combinationally equal to the cycle's winning write before the output register.
  - Decode uses these to forward a result in the same cycle it is committed, covering the window where the register file read still returns the old value.
  - When undefined these ports do not exist and behaviour is otherwise identical.

Decomposition:
- Package wb_pkg:
  - localparams for REGISTERS/WIDTH defaults;
  - typedef wb_req_t struct {rd, data};
  - enum wb_src_t {SRC_NONE, SRC_ALU, SRC_LD}, used for the winner select.
- Sub-module wb_fifo: synchronous, parameterised by depth and wb_req_t, with push/pop/full/empty/count and no fall-through.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF at cycle 1 -> wb_we=1, wb_addr=5, wb_data=0xDEADBEEF in cycle 2; alu_ready stays 1.
- x0 filter: ALU rd=0 data=0x1234, then load rd=0 -> wb_we never asserts and the FIFO stays empty.
- Load only: ld rd=7 data=0xA5A5A5A5 in cycle 1 -> wb_we with addr 7 in cycle 3; ld_pending high in cycle 2 only.
- Backpressure: push 4 loads (rd 1..4) while the ALU is valid every cycle -> ld_ready=0 after the 4th push. Drain order 1,2,3,4 is interleaved with ALU writes.
- Starvation, STARVE_LIMIT=3: continuous ALU rd=9 with 1 buffered load -> exactly 3 ALU writes, then alu_ready=0 for one cycle and the load is written, then ALU writes resume.
- Assert rst_n=0 mid-drain with 3 entries buffered -> wb_we=0 immediately, ld_ready=1, ld_pending=0; no stale writes after release.
